seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 25 ++
 rtl/bin2bcd_iter.sv | 63 ++++++
 rtl/seg_scan_driver.sv | 115 +++++++++++
 tb/tb_seg_scan_driver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants and types for the seg_scan_driver slice.
//   SEG_BLANK / SEG_MINUS : special digit codes understood by the decoder
//   DIG_*                 : digit-select values driven on `en`
//   MAX_MAG               : largest magnitude that fits in three BCD digits
//   state_t               : conversion FSM states
package seg_pkg;

    localparam logic [3:0] SEG_BLANK = 4'd14;
    localparam logic [3:0] SEG_MINUS = 4'd15;

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_SIGN     = 2'd3;

    localparam int unsigned MAX_MAG = 999;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ABS,
        S_SHIFT,
        S_COMMIT
    } state_t;

endpackage

// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter -- iterative double-dabble converter, one bit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   start_i    : load bin_i and begin W iterations
//   bin_i      : unsigned binary input (value must be <= 999)
//   last_o     : high during the cycle in which the final iteration happens;
//                bcd_o is final from the following cycle on
//   bcd_o      : 12-bit packed BCD {hundreds, tens, units}
module bin2bcd_iter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] bin_i,
    output logic         last_o,
    output logic [11:0]  bcd_o
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     bin_q, bin_d;
    logic [11:0]      bcd_q, bcd_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // add-3 correction on every nibble that would overflow past 9 when doubled
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = CNT_W'(W);
        end else if (cnt_q != '0) begin
            bcd_d = {adj[10:0], bin_q[W-1]};
            bin_d = {bin_q[W-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_o = !start_i && (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver -- signed value to sign + 3 BCD digits, time-multiplexed
// onto a 4-digit common-anode display decoder.
//   clk, rst_n : clock, synchronous active-low reset
//   value      : signed (two's complement) value, captured on load when idle
//   load       : one-cycle capture strobe, ignored while busy
//   busy       : conversion in progress
//   en         : digit select (3 sign, 2 hundreds, 1 tens, 0 units)
//   num        : digit code (0-9, 14 blank/plus, 15 minus)
// Optional: define SEG_LEAD_ZERO_BLANK_EN to blank leading zeros on commit.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int DATA_W     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    output logic              busy,
    output logic [1:0]        en,
    output logic [3:0]        num
);

    localparam int DIV   = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W = $clog2(DIV);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   val_q;
    logic [DATA_W:0]     mag_full;
    logic [DATA_W-1:0]   mag_sat;
    logic                bcd_last;
    logic [11:0]         bcd;
    logic [3:0][3:0]     sh_q, sh_d;
    logic [CNT_W-1:0]    rcnt_q, rcnt_d;
    logic [1:0]          en_q, en_d;
    logic [3:0]          num_q, num_d;

    // one extra bit so that the most negative input has a representable magnitude
    always_comb begin
        if (val_q[DATA_W-1]) mag_full = -{val_q[DATA_W-1], val_q};
        else                 mag_full = {1'b0, val_q};
        if (mag_full > (DATA_W+1)'(MAX_MAG)) mag_sat = DATA_W'(MAX_MAG);
        else                                 mag_sat = mag_full[DATA_W-1:0];
    end

    bin2bcd_iter #(.W(DATA_W)) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (state_q == S_ABS),
        .bin_i   (mag_sat),
        .last_o  (bcd_last),
        .bcd_o   (bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load) state_d = S_ABS;
            S_ABS:    state_d = S_SHIFT;
            S_SHIFT:  if (bcd_last) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sh_d = sh_q;
        if (state_q == S_COMMIT) begin
            sh_d[DIG_SIGN]     = val_q[DATA_W-1] ? SEG_MINUS : SEG_BLANK;
            sh_d[DIG_HUNDREDS] = bcd[11:8];
            sh_d[DIG_TENS]     = bcd[7:4];
            sh_d[DIG_UNITS]    = bcd[3:0];
`ifdef SEG_LEAD_ZERO_BLANK_EN
            if (bcd[11:8] == 4'd0) sh_d[DIG_HUNDREDS] = SEG_BLANK;
            if (bcd[11:4] == 8'd0) sh_d[DIG_TENS]     = SEG_BLANK;
`endif
        end
    end

    // num follows the next-state shadow so a commit shows up without waiting for a tick
    always_comb begin
        rcnt_d = rcnt_q + 1'b1;
        en_d   = en_q;
        if (rcnt_q == CNT_W'(DIV - 1)) begin
            rcnt_d = '0;
            en_d   = en_q + 2'd1;
        end
        num_d = sh_d[en_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            sh_q    <= {SEG_BLANK, 4'd0, 4'd0, 4'd0};
            rcnt_q  <= '0;
            en_q    <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && load) val_q <= value;
            sh_q    <= sh_d;
            rcnt_q  <= rcnt_d;
            en_q    <= en_d;
            num_q   <= num_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign en   = en_q;
    assign num  = num_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver -- scoreboard bench for seg_scan_driver.
// A reference model tracks acceptance/busy time and the scan position in plain
// arithmetic and queues the expected 4-digit display per accepted load; a
// monitor pops it when the DUT drops busy and checks busy/en/num every cycle.
// Honors SEG_LEAD_ZERO_BLANK_EN the same way as the design.
module tb_seg_scan_driver;

    localparam int CLK_HZ     = 400;
    localparam int REFRESH_HZ = 100;
    localparam int DATA_W     = 11;
    localparam int PER        = CLK_HZ / REFRESH_HZ;
    localparam logic [15:0] RESET_DISP = 16'hE000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic [DATA_W-1:0] value = '0;
    logic              busy;
    logic [1:0]        en;
    logic [3:0]        num;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ),
        .DATA_W     (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .load  (load),
        .busy  (busy),
        .en    (en),
        .num   (num)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q[$];       // {sign, hundreds, tens, units}
    logic [15:0] cur_disp = RESET_DISP;
    int          n = 0;          // clock edges since reset release
    int          busy_left = 0;  // cycles of busy still expected
    bit          edge_rst = 1'b1;

    function automatic logic [15:0] ref_disp(int v);
        int mag, h, t, u;
        logic [15:0] d;
        mag = (v < 0) ? -v : v;
        if (mag > 999) mag = 999;
        h = mag / 100;
        t = (mag / 10) % 10;
        u = mag % 10;
        d = {(v < 0) ? 4'd15 : 4'd14, 4'(h), 4'(t), 4'(u)};
`ifdef SEG_LEAD_ZERO_BLANK_EN
        if (h == 0)   d[11:8] = 4'd14;
        if (mag < 10) d[7:4]  = 4'd14;
`endif
        return d;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: acceptance and busy duration
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            n         = 0;
            busy_left = 0;
            edge_rst  = 1'b1;
        end else begin
            edge_rst = 1'b0;
            n++;
            if (busy_left > 0) busy_left--;
            else if (load) begin
                busy_left = DATA_W + 2;
                exp_q.push_back(ref_disp(int'($signed(value))));
            end
        end
    end

    // monitor
    initial begin
        bit prev_busy;
        int e;
        prev_busy = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                cur_disp  = RESET_DISP;
                prev_busy = 1'b0;
            end
            // skip the one sample where reset was raised but not yet clocked in
            if (rst_n || edge_rst) begin
                if (rst_n && prev_busy && !busy) begin
                    chk("result_queued", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) cur_disp = exp_q.pop_front();
                end
                e = (n / PER) % 4;
                chk("busy", int'(busy), int'(busy_left > 0));
                chk("en", int'(en), e);
                chk("num", int'(num), int'(cur_disp[4*e +: 4]));
                prev_busy = busy;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int v);
        value = DATA_W'(v);
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
    endtask

    int vals[10] = '{427, -38, 1023, -1024, 0, -5, 999, -1, 10, -100};
    int v;

    initial begin
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(16);

        foreach (vals[i]) begin
            pulse(vals[i]);
            tick(DATA_W + 2 + 16);
        end

        // second load during busy is dropped; one landing as busy falls is taken
        pulse(111);
        tick(4);
        pulse(222);
        tick(DATA_W - 4);
        pulse(222);
        tick(DATA_W + 2 + 16);

        // reset in the middle of a conversion
        pulse(123);
        tick(DATA_W + 2 + 16);
        pulse(500);
        tick(5);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(20);

        repeat (40) begin
            v = int'($urandom_range(0, 2047)) - 1024;
            pulse(v);
            tick(int'($urandom_range(0, DATA_W + 8)));
            if ($urandom_range(0, 3) == 0) begin
                pulse(int'($urandom_range(0, 2047)) - 1024);
            end
        end
        tick(DATA_W + 2 + 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
